sid_write_sched: RTL and testbench
==================================

Name: sid_write_sched

Overview:
- Timed register-write scheduler and bus arbiter in front of the IceSID core.
- Host (network/player side) pushes {delta, addr, data} records into an internal FIFO. The block replays each write onto the SID write port exactly `delta` clkEn ticks after the previous write.
- Shares the same SID address bus with an asynchronous host register-read path.

Parameters:
- DEPTH, 64, FIFO entries; must be a power of 2, at least 4.
- DELTA_W, 16, width of the per-record tick delay.

Ports:
- clk  in  1  master clock.
- iRstN  in  1  reset, asynchronous, active-low.
- clkEn  in  1  1MHz SID tick; guaranteed at least 4 clk apart.
- iRun  in  1  1 = replay enabled; 0 = pause (tick counter frozen).
- iFlush  in  1  single-cycle pulse: empty FIFO, clear oUnderrun, abort pending write.
- iPushValid  in  1  record valid.
- oPushReady  out  1  FIFO not full.
- iPushDelta  in  DELTA_W  ticks since previous issued write.
- iPushAddr  in  5  SID register address.
- iPushData  in  8  SID register data.
- iRdReq  in  1  single-cycle host read request.
- iRdAddr  in  5  read address.
- oRdValid  out  1  one-cycle pulse, read data valid.
- oRdData  out  8  read data.
- oSidWE  out  1  to SID iWE.
- oSidAddr  out  5  to SID iAddr.
- oSidData  out  8  to SID iDataW.
- iSidDataR  in  8  from SID oDataR (combinational on oSidAddr).
- oLevel  out  clog2(DEPTH)+1  FIFO occupancy.
- oUnderrun  out  1  sticky: FIFO ran empty while iRun=1 after an issue.

Behaviour:
- Reset values (iRstN low, async): all outputs 0, except oPushReady=1. FIFO empty, state IDLE.
- FIFO
  - A push is accepted when iPushValid and oPushReady are both high.
  - A push and a pop in the same cycle are both accepted; oLevel is unchanged.
  - oPushReady=0 at oLevel==DEPTH.
  - Read and write pointers wrap modulo DEPTH.
- FSM
  - IDLE: FIFO non-empty and iRun -> LOAD.
  - LOAD: pop the head into the hold registers; cnt <= delta -> WAIT.
  - WAIT: on a clkEn tick with iRun=1: if cnt<=1 -> ISSUE, else cnt--. Delta 0 and 1 both mean "next tick". Ticks are ignored while iRun=0.
  - ISSUE (1 clk): oSidWE=1, oSidAddr/oSidData = hold registers (registered outputs). Next state: FIFO non-empty -> LOAD; else IDLE, and oUnderrun<=1 if iRun=1.
  - LOAD completes in 1 clk, so a record popped after a tick always meets the next tick.
- Timebase: the first record after IDLE counts its delta from the LOAD cycle, not from the last issue.
- Read arbitration
  - A pending read is latched; at most 1 is outstanding, and further iRdReq while pending are dropped.
  - A read is served in any cycle whose next state is not ISSUE: drive oSidAddr=iRdAddr with oSidWE=0.
  - The following cycle, sample iSidDataR into oRdData and pulse oRdValid.
  - When a write is due in the same cycle, the write wins and the read slips 1 cycle. Worst-case read latency is 3 clk.
- iFlush
  - Takes effect in the following cycle; any state -> IDLE. The hold record is discarded and a read in flight still completes.
  - A flush in the same cycle as a push: the push is discarded.
  - A flush in the same cycle as ISSUE: that write is still driven; the FIFO is cleared afterwards.
- Arithmetic: cnt is DELTA_W bits unsigned and never underflows (guarded by the <=1 compare).

Optional Feature:
- Macro: SID_SCHED_SHADOW_EN.
- Defined:
  - A 25x8 shadow register file is written on every ISSUE.
  - Host reads of 0x00–0x18 return the shadow value with oRdValid 1 clk after iRdReq, with no SID bus access.
  - Reads of 0x19–0x1F still go to the SID bus.
  - Shadow resets to 0; iFlush does not clear it.
- Undefined: all reads go to the SID bus. Write-only registers then return the SID's last-written value.

Decomposition:
- Shared package sid_sched_pkg:
  - FSM state encoding (IDLE, LOAD, WAIT, ISSUE).
  - Record width constant (DELTA_W+13).
  - SID_REG_COUNT=25 and SID_ADDR_W=5.
- Sub-module sid_sched_fifo: synchronous FIFO with DEPTH, level output and flush.

Test Plan:
- Push {0,0x18,0x0F}, {100,0x01,0x22}, iRun=1 -> oSidWE at tick 1 (addr 0x18 data 0x0F), then exactly 100 ticks later (addr 0x01 data 0x22). oUnderrun=1 afterwards.
- Fill with 64 records, delta=1000 -> oPushReady=0 at oLevel=64; a 65th push is ignored. After the first ISSUE, oPushReady=1 and oLevel=63.
- Record delta=10, iRun dropped for 5 ticks after tick 3 -> write issues at tick 15.
- iRdReq addr 0x1B in the same cycle a write is due -> write to SID first; oRdValid 2 clk later carries iSidDataR for 0x1B.
- Mid-WAIT iFlush, plus a push in the same cycle -> no oSidWE, oLevel=0, oUnderrun=0. Async iRstN low mid-ISSUE -> oSidWE drops immediately.
- With SID_SCHED_SHADOW_EN: issue {0,0x04,0x41}, read 0x04 -> oRdData=0x41 one clk after iRdReq, no SID bus cycle.

Source files
------------

// File: rtl/sid_sched_pkg.sv
// Shared types and constants for the SID timed write scheduler.
package sid_sched_pkg;

    localparam int unsigned SID_REG_COUNT = 25;
    localparam int unsigned SID_ADDR_W    = 5;
    localparam int unsigned SID_DATA_W    = 8;
    localparam int unsigned REC_PAYLOAD_W = SID_ADDR_W + SID_DATA_W;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StIssue
    } sched_state_e;

    // Record layout is {delta, addr, data}.
    function automatic int unsigned rec_width(input int unsigned delta_w);
        return delta_w + REC_PAYLOAD_W;
    endfunction

endpackage

// File: rtl/sid_sched_fifo.sv
// Synchronous record FIFO with occupancy output and single-cycle flush.
module sid_sched_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 29
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (PtrW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // Flush wins over a same-cycle push or pop.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PtrW'(1);
            if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + (PtrW+1)'(1);
                2'b01:   level_d = level_q - (PtrW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sid_write_sched.sv
// Timed SID register-write replay scheduler with host read arbitration.
// Optional shadow register file for host reads: define SID_SCHED_SHADOW_EN.
module sid_write_sched
    import sid_sched_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned DELTA_W = 16
) (
    input  logic                     clk,
    input  logic                     iRstN,
    input  logic                     clkEn,
    input  logic                     iRun,
    input  logic                     iFlush,
    input  logic                     iPushValid,
    output logic                     oPushReady,
    input  logic [DELTA_W-1:0]       iPushDelta,
    input  logic [4:0]               iPushAddr,
    input  logic [7:0]               iPushData,
    input  logic                     iRdReq,
    input  logic [4:0]               iRdAddr,
    output logic                     oRdValid,
    output logic [7:0]               oRdData,
    output logic                     oSidWE,
    output logic [4:0]               oSidAddr,
    output logic [7:0]               oSidData,
    input  logic [7:0]               iSidDataR,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oUnderrun
);

    localparam int unsigned RecW = rec_width(DELTA_W);

    sched_state_e            state_q, state_d;
    logic [DELTA_W-1:0]      cnt_q, cnt_d;
    logic [SID_ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [SID_DATA_W-1:0]   hold_data_q, hold_data_d;
    logic                    underrun_q, underrun_d;
    logic                    we_q, we_d;
    logic [SID_ADDR_W-1:0]   sid_addr_q, sid_addr_d;
    logic [SID_DATA_W-1:0]   sid_data_q, sid_data_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [SID_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_bus_q, rd_bus_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [SID_DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [RecW-1:0]         head;
    logic                    fifo_empty, fifo_full;
    logic                    issue_next;
    logic                    rd_new, rd_new_bus, rd_shadow, rd_want, rd_serve;
    logic [SID_ADDR_W-1:0]   rd_want_addr;

    sid_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RecW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (iRstN),
        .flush_i (iFlush),
        .push_i  (iPushValid),
        .wdata_i ({iPushDelta, iPushAddr, iPushData}),
        .pop_i   (state_q == StLoad),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (oLevel)
    );

    assign oPushReady = !fifo_full;
    assign oUnderrun  = underrun_q;
    assign oSidWE     = we_q;
    assign oSidAddr   = sid_addr_q;
    assign oSidData   = sid_data_q;
    assign oRdValid   = rd_valid_q;
    assign oRdData    = rd_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        underrun_d  = underrun_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && iRun) state_d = StLoad;
            end
            StLoad: begin
                cnt_d       = head[RecW-1 -: DELTA_W];
                hold_addr_d = head[SID_DATA_W +: SID_ADDR_W];
                hold_data_d = head[SID_DATA_W-1:0];
                state_d     = StWait;
            end
            StWait: begin
                // Delta 0 and 1 both fire on the next tick; cnt never wraps.
                if (clkEn && iRun) begin
                    if (cnt_q <= DELTA_W'(1)) state_d = StIssue;
                    else                      cnt_d   = cnt_q - DELTA_W'(1);
                end
            end
            StIssue: begin
                if (!fifo_empty) begin
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                    if (iRun) underrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (iFlush) begin
            state_d    = StIdle;
            underrun_d = 1'b0;
        end
    end

`ifdef SID_SCHED_SHADOW_EN
    localparam logic [SID_ADDR_W-1:0] ShadowLim = SID_ADDR_W'(SID_REG_COUNT);

    logic [SID_DATA_W-1:0] shadow_q [SID_REG_COUNT];

    assign rd_shadow = rd_new && (iRdAddr < ShadowLim);

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < int'(SID_REG_COUNT); i++) shadow_q[i] <= '0;
        end else if (issue_next && (hold_addr_q < ShadowLim)) begin
            shadow_q[hold_addr_q] <= hold_data_q;
        end
    end
`else
    assign rd_shadow = 1'b0;
`endif

    assign issue_next   = (state_d == StIssue);
    assign rd_new       = iRdReq && !rd_pend_q && !rd_bus_q;
    assign rd_new_bus   = rd_new && !rd_shadow;
    assign rd_want      = rd_pend_q || rd_new_bus;
    assign rd_want_addr = rd_pend_q ? rd_addr_q : iRdAddr;
    // A due write owns the bus; the read waits one cycle in the pending slot.
    assign rd_serve     = rd_want && !issue_next;

    always_comb begin
        we_d       = issue_next;
        sid_addr_d = sid_addr_q;
        sid_data_d = sid_data_q;
        rd_pend_d  = rd_want && !rd_serve;
        rd_addr_d  = rd_want ? rd_want_addr : rd_addr_q;
        rd_bus_d   = rd_serve;
        rd_valid_d = rd_bus_q;
        rd_data_d  = rd_bus_q ? iSidDataR : rd_data_q;
        if (issue_next) begin
            sid_addr_d = hold_addr_q;
            sid_data_d = hold_data_q;
        end else if (rd_serve) begin
            sid_addr_d = rd_want_addr;
        end
`ifdef SID_SCHED_SHADOW_EN
        if (rd_shadow) begin
            rd_valid_d = 1'b1;
            rd_data_d  = shadow_q[iRdAddr];
        end
`endif
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            underrun_q  <= 1'b0;
            we_q        <= 1'b0;
            sid_addr_q  <= '0;
            sid_data_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_bus_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            underrun_q  <= underrun_d;
            we_q        <= we_d;
            sid_addr_q  <= sid_addr_d;
            sid_data_q  <= sid_data_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            rd_bus_q    <= rd_bus_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_sid_write_sched.sv
// Directed self-checking bench for sid_write_sched.
module tb_sid_write_sched;

    localparam int unsigned DEPTH   = 64;
    localparam int unsigned DELTA_W = 16;

    logic               clk = 1'b0;
    logic               iRstN;
    logic               clkEn;
    logic               iRun;
    logic               iFlush;
    logic               iPushValid;
    logic               oPushReady;
    logic [DELTA_W-1:0] iPushDelta;
    logic [4:0]         iPushAddr;
    logic [7:0]         iPushData;
    logic               iRdReq;
    logic [4:0]         iRdAddr;
    logic               oRdValid;
    logic [7:0]         oRdData;
    logic               oSidWE;
    logic [4:0]         oSidAddr;
    logic [7:0]         oSidData;
    logic [7:0]         iSidDataR;
    logic [6:0]         oLevel;
    logic               oUnderrun;

    int n_vec = 0;
    int n_err = 0;
    int tick_no = 0;
    int we_total = 0;
    int last_tick = 0;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always #5 clk = ~clk;

    // SID read model: data is a fixed function of the address on the bus.
    assign iSidDataR = {oSidAddr, 3'b011};

    sid_write_sched #(
        .DEPTH   (DEPTH),
        .DELTA_W (DELTA_W)
    ) dut (
        .clk        (clk),
        .iRstN      (iRstN),
        .clkEn      (clkEn),
        .iRun       (iRun),
        .iFlush     (iFlush),
        .iPushValid (iPushValid),
        .oPushReady (oPushReady),
        .iPushDelta (iPushDelta),
        .iPushAddr  (iPushAddr),
        .iPushData  (iPushData),
        .iRdReq     (iRdReq),
        .iRdAddr    (iRdAddr),
        .oRdValid   (oRdValid),
        .oRdData    (oRdData),
        .oSidWE     (oSidWE),
        .oSidAddr   (oSidAddr),
        .oSidData   (oSidData),
        .iSidDataR  (iSidDataR),
        .oLevel     (oLevel),
        .oUnderrun  (oUnderrun)
    );

    always @(negedge clk) begin
        if (oSidWE === 1'b1) begin
            we_total  <= we_total + 1;
            last_tick <= tick_no;
            last_addr <= oSidAddr;
            last_data <= oSidData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        clkEn = 1'b1;
        tick_no++;
        step();
        clkEn = 1'b0;
        repeat (3) step();
    endtask

    task automatic push(input logic [15:0] d, input logic [4:0] a, input logic [7:0] v);
        iPushValid = 1'b1;
        iPushDelta = d;
        iPushAddr  = a;
        iPushData  = v;
        step();
        iPushValid = 1'b0;
    endtask

    task automatic flush();
        iFlush = 1'b1;
        step();
        iFlush = 1'b0;
    endtask

    initial begin
        int base;
        int w0;
        iRstN = 1'b0; clkEn = 1'b0; iRun = 1'b0; iFlush = 1'b0;
        iPushValid = 1'b0; iPushDelta = '0; iPushAddr = '0; iPushData = '0;
        iRdReq = 1'b0; iRdAddr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(oPushReady), 32'd1);
        chk("rst_we", 32'(oSidWE), 32'd0);
        chk("rst_level", 32'(oLevel), 32'd0);
        chk("rst_underrun", 32'(oUnderrun), 32'd0);
        chk("rst_rdvalid", 32'(oRdValid), 32'd0);
        chk("rst_sidaddr", 32'(oSidAddr), 32'd0);
        iRstN = 1'b1;
        step();

        // Two records: delta 0 then delta 100.
        push(16'd0, 5'h18, 8'h0F);
        push(16'd100, 5'h01, 8'h22);
        chk("t1_level2", 32'(oLevel), 32'd2);
        iRun = 1'b1;
        step(); step();
        base = tick_no; w0 = we_total;
        do_tick();
        chk("t1_first_cnt", 32'(we_total), 32'(w0 + 1));
        chk("t1_first_tick", 32'(last_tick), 32'(base + 1));
        chk("t1_first_addr", 32'(last_addr), 32'h18);
        chk("t1_first_data", 32'(last_data), 32'h0F);
        repeat (99) do_tick();
        chk("t1_no_early", 32'(we_total), 32'(w0 + 1));
        do_tick();
        chk("t1_second_cnt", 32'(we_total), 32'(w0 + 2));
        chk("t1_second_tick", 32'(last_tick), 32'(base + 101));
        chk("t1_second_addr", 32'(last_addr), 32'h01);
        chk("t1_second_data", 32'(last_data), 32'h22);
        chk("t1_underrun", 32'(oUnderrun), 32'd1);

        // Fill to capacity while paused.
        iRun = 1'b0;
        flush();
        chk("t2_flush_underrun", 32'(oUnderrun), 32'd0);
        for (int i = 0; i < 64; i++) push(16'd1000, i[4:0], i[7:0]);
        chk("t2_full_ready", 32'(oPushReady), 32'd0);
        chk("t2_full_level", 32'(oLevel), 32'd64);
        push(16'd1000, 5'h1F, 8'hFF);
        chk("t2_65th_ignored", 32'(oLevel), 32'd64);
        iRun = 1'b1;
        step(); step();
        w0 = we_total;
        repeat (999) do_tick();
        chk("t2_no_early", 32'(we_total), 32'(w0));
        clkEn = 1'b1; tick_no++;
        step();
        clkEn = 1'b0;
        chk("t2_issue_we", 32'(oSidWE), 32'd1);
        chk("t2_issue_addr", 32'(oSidAddr), 32'h00);
        chk("t2_issue_level", 32'(oLevel), 32'd63);
        chk("t2_issue_ready", 32'(oPushReady), 32'd1);
        repeat (3) step();
        iRun = 1'b0;
        flush();
        chk("t2_flushed_level", 32'(oLevel), 32'd0);

        // Pause for five ticks after tick 3 of a delta-10 record.
        iRun = 1'b1;
        push(16'd10, 5'h05, 8'hAA);
        step(); step();
        base = tick_no; w0 = we_total;
        repeat (3) do_tick();
        iRun = 1'b0;
        repeat (5) do_tick();
        iRun = 1'b1;
        repeat (6) do_tick();
        chk("t3_no_early", 32'(we_total), 32'(w0));
        do_tick();
        chk("t3_issue_cnt", 32'(we_total), 32'(w0 + 1));
        chk("t3_issue_tick", 32'(last_tick), 32'(base + 15));
        chk("t3_issue_data", 32'(last_data), 32'hAA);

        // Read collides with a due write.
        flush();
        push(16'd2, 5'h0A, 8'h55);
        step(); step();
        do_tick();
        clkEn = 1'b1; tick_no++;
        iRdReq = 1'b1; iRdAddr = 5'h1B;
        step();
        clkEn = 1'b0; iRdReq = 1'b0;
        chk("t4_write_we", 32'(oSidWE), 32'd1);
        chk("t4_write_addr", 32'(oSidAddr), 32'h0A);
        chk("t4_write_data", 32'(oSidData), 32'h55);
        chk("t4_no_rdvalid0", 32'(oRdValid), 32'd0);
        step();
        chk("t4_rd_bus_addr", 32'(oSidAddr), 32'h1B);
        chk("t4_rd_bus_we", 32'(oSidWE), 32'd0);
        chk("t4_no_rdvalid1", 32'(oRdValid), 32'd0);
        step();
        chk("t4_rdvalid", 32'(oRdValid), 32'd1);
        chk("t4_rddata", 32'(oRdData), 32'hDB);
        step();
        chk("t4_rdvalid_pulse", 32'(oRdValid), 32'd0);
        iRdReq = 1'b1; iRdAddr = 5'h1C;
        step();
        iRdReq = 1'b0;
        chk("t4b_bus_addr", 32'(oSidAddr), 32'h1C);
        step();
        chk("t4b_rdvalid", 32'(oRdValid), 32'd1);
        chk("t4b_rddata", 32'(oRdData), 32'hE3);

        // Flush mid-wait with a same-cycle push.
        chk("t5_underrun_set", 32'(oUnderrun), 32'd1);
        push(16'd3, 5'h07, 8'h77);
        step(); step();
        do_tick();
        iFlush = 1'b1;
        iPushValid = 1'b1; iPushDelta = 16'd1; iPushAddr = 5'h08; iPushData = 8'h88;
        step();
        iFlush = 1'b0; iPushValid = 1'b0;
        chk("t5_level", 32'(oLevel), 32'd0);
        chk("t5_underrun", 32'(oUnderrun), 32'd0);
        w0 = we_total;
        repeat (4) do_tick();
        chk("t5_no_write", 32'(we_total), 32'(w0));

        // Asynchronous reset during an issue cycle.
        push(16'd0, 5'h03, 8'h33);
        step(); step();
        clkEn = 1'b1; tick_no++;
        step();
        clkEn = 1'b0;
        chk("t6_issue_we", 32'(oSidWE), 32'd1);
        #2 iRstN = 1'b0;
        #1;
        chk("t6_async_we", 32'(oSidWE), 32'd0);
        chk("t6_async_addr", 32'(oSidAddr), 32'd0);
        chk("t6_async_level", 32'(oLevel), 32'd0);
        @(posedge clk);
        #1 iRstN = 1'b1;
        step();

`ifdef SID_SCHED_SHADOW_EN
        push(16'd0, 5'h04, 8'h41);
        step(); step();
        do_tick();
        iRdReq = 1'b1; iRdAddr = 5'h1C;
        step();
        iRdReq = 1'b0;
        step(); step();
        chk("t7_bus_addr", 32'(oSidAddr), 32'h1C);
        iRdReq = 1'b1; iRdAddr = 5'h04;
        step();
        iRdReq = 1'b0;
        chk("t7_shadow_valid", 32'(oRdValid), 32'd1);
        chk("t7_shadow_data", 32'(oRdData), 32'h41);
        chk("t7_no_bus", 32'(oSidAddr), 32'h1C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
